uart_parity_rx: RTL and testbench

//  UART receiver for 8 data bits, even parity and 1 stop bit (8E1). LSB first, idle-high line.

---
 rtl/uart_parity_rx.sv | 164 ++++++++++++++++
 tb/tb_uart_parity_rx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_parity_rx.sv
// 8E1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, byte + parity/framing flags
// presented with a single-cycle read_complete strobe.
module uart_parity_rx #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic [7:0] read_value,
    output logic       read_complete,
    output logic       read_error,
    output logic       parity_error,
    output logic       frame_error,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_sync1;
    logic            r_sync2;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic            r_par;
    logic [7:0]      r_read_value;
    logic            r_read_complete;
    logic            r_parity_error;
    logic            r_frame_error;
    logic            r_read_error;

    logic            w_rxd;
    logic            w_bit_end;
    logic            w_half_end;
    logic            w_cnt_clr;
    logic            w_sample_data;
    logic            w_sample_par;
    logic            w_done;
    logic            w_par_err;
    logic            w_frm_err;

    assign w_rxd      = r_sync2;
    assign w_bit_end  = (r_cnt == CW'(CLKS_PER_BIT - 1));
    assign w_half_end = (r_cnt == CW'(HALF_BIT - 1));
    assign w_par_err  = ^{r_shift, r_par};
    assign w_frm_err  = ~w_rxd;

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= uart_rxd;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_clr ? '0 : r_cnt + CW'(1);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_clr     = 1'b0;
        w_sample_data = 1'b0;
        w_sample_par  = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_clr = 1'b1;
                if (!w_rxd) w_state_nxt = S_START;
            end
            S_START: begin
                // Line back high at the start-bit centre means a glitch, not a frame.
                if (w_half_end) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = w_rxd ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_clr     = 1'b1;
                    w_sample_data = 1'b1;
                    if (r_idx == 3'd7) w_state_nxt = S_PARITY;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_cnt_clr    = 1'b1;
                    w_sample_par = 1'b1;
                    w_state_nxt  = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt_clr   = 1'b1;
                    w_done      = 1'b1;
                    w_state_nxt = w_rxd ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                w_cnt_clr = 1'b1;
                if (w_rxd) w_state_nxt = S_IDLE;
            end
            default: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
        end else begin
            if (r_state != S_DATA)  r_idx <= '0;
            else if (w_sample_data) r_idx <= r_idx + 3'd1;
            if (w_sample_data)      r_shift[r_idx] <= w_rxd;
            if (w_sample_par)       r_par <= w_rxd;
        end
    end

    // Result registers are only touched on frame completion, so they hold across glitches.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_read_value    <= '0;
            r_read_complete <= 1'b0;
            r_parity_error  <= 1'b0;
            r_frame_error   <= 1'b0;
            r_read_error    <= 1'b0;
        end else begin
            r_read_complete <= w_done;
            if (w_done) begin
                r_read_value   <= r_shift;
                r_parity_error <= w_par_err;
                r_frame_error  <= w_frm_err;
                r_read_error   <= w_par_err | w_frm_err;
            end
        end
    end

    assign read_value    = r_read_value;
    assign read_complete = r_read_complete;
    assign parity_error  = r_parity_error;
    assign frame_error   = r_frame_error;
    assign read_error    = r_read_error;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_parity_rx.sv
// Bench for uart_parity_rx: directed 8E1 scenarios plus random frames against a queue-based model.
// Bit period is shortened to 32 clocks so the whole run stays small.
module tb_uart_parity_rx;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 1_562_500;
    localparam int C        = CLK_FREQ / BAUD;
    localparam int H        = C / 2;
    // 2 synchroniser clocks plus the receiver's own start-to-strobe figure
    localparam int NOM      = 2 + H + 10 * C - 1;

    logic       clk_50M = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rxd = 1'b1;
    logic [7:0] read_value;
    logic       read_complete;
    logic       read_error;
    logic       parity_error;
    logic       frame_error;
    logic       busy;

    uart_parity_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk_50M       (clk_50M),
        .reset         (reset),
        .uart_rxd      (uart_rxd),
        .read_value    (read_value),
        .read_complete (read_complete),
        .read_error    (read_error),
        .parity_error  (parity_error),
        .frame_error   (frame_error),
        .busy          (busy)
    );

    always #10 clk_50M = ~clk_50M;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         t0;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   mon_lat;
    int   cyc = 0;
    int   n_tot = 0;
    int   n_bad = 0;
    int   n_strb = 0;
    int   n_sent = 0;
    logic prev_rc = 1'b0;

    always @(posedge clk_50M) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every strobe is matched against the oldest outstanding frame of the model.
    always @(negedge clk_50M) begin
        if (read_complete) begin
            n_strb++;
            chk("strobe_1clk", 32'(prev_rc), 0);
            if (exp_q.size() == 0) begin
                chk("spurious_strobe", 1, 0);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_lat = cyc - mon_e.t0;
                chk($sformatf("latency_%0d", mon_lat),
                    32'(mon_lat >= NOM - 2 && mon_lat <= NOM + 2), 1);
                chk("read_value",   32'(read_value),   32'(mon_e.data));
                chk("parity_error", 32'(parity_error), 32'(mon_e.perr));
                chk("frame_error",  32'(frame_error),  32'(mon_e.ferr));
                chk("read_error",   32'(read_error),   32'(mon_e.perr | mon_e.ferr));
            end
        end
        prev_rc <= read_complete;
    end

    task automatic drive_bit(input logic b);
        uart_rxd = b;
        repeat (C) @(negedge clk_50M);
    endtask

    task automatic idle(input int n);
        uart_rxd = 1'b1;
        repeat (n) @(negedge clk_50M);
    endtask

    // Leaves the line at the stop-bit level; a low stop bit is the caller's to release.
    task automatic send(input logic [7:0] d, input logic pbit, input logic stop);
        exp_t e;
        e.data = d;
        e.perr = (^d) ^ pbit;
        e.ferr = ~stop;
        e.t0   = cyc + 1;
        exp_q.push_back(e);
        n_sent++;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(pbit);
        drive_bit(stop);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_value"},  32'(read_value),    0);
        chk({tag, "_rc"},     32'(read_complete), 0);
        chk({tag, "_rerr"},   32'(read_error),    0);
        chk({tag, "_perr"},   32'(parity_error),  0);
        chk({tag, "_ferr"},   32'(frame_error),   0);
        chk({tag, "_busy"},   32'(busy),          0);
    endtask

    initial begin
        int s0;
        int w;
        logic [7:0] d;
        logic       pb;
        logic       st;

        repeat (3) @(negedge clk_50M);
        chk_zero("rst");
        reset = 1'b0;
        idle(C);

        // 1: clean byte
        send(8'h78, 1'b0, 1'b1);
        idle(C);
        chk("t1_strobes", n_strb, 1);

        // 2: back-to-back frames
        send(8'h9A, 1'b0, 1'b1);
        send(8'hBC, 1'b1, 1'b1);
        idle(C);
        chk("t2_strobes", n_strb, 3);

        // 3: wrong parity
        send(8'hDE, 1'b1, 1'b1);
        idle(C);
        chk("t3_strobes", n_strb, 4);

        // 4: short low glitch is rejected at the start-bit centre
        s0 = n_strb;
        uart_rxd = 1'b0;
        repeat (4) @(negedge clk_50M);
        chk("t4_busy_hi", 32'(busy), 1);
        repeat (2) @(negedge clk_50M);
        uart_rxd = 1'b1;
        repeat (H - 2) @(negedge clk_50M);
        chk("t4_busy_lo", 32'(busy), 0);
        idle(C);
        chk("t4_no_strobe", n_strb, s0);
        chk("t4_hold_value", 32'(read_value), 32'h00DE);
        chk("t4_hold_perr",  32'(parity_error), 1);
        chk("t4_hold_rerr",  32'(read_error), 1);

        // 5: framing error followed by a held-low line, then a clean frame
        send(8'h55, 1'b0, 1'b0);
        repeat (3 * C) @(negedge clk_50M);
        chk("t5_busy_break", 32'(busy), 1);
        idle(C);
        chk("t5_busy_idle", 32'(busy), 0);
        chk("t5_strobes", n_strb, 5);
        send(8'h33, 1'b0, 1'b1);
        idle(C);
        chk("t5_strobes2", n_strb, 6);

        // 6: reset during data bit 4 of 0xA5 aborts the frame
        s0 = n_strb;
        d = 8'hA5;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        uart_rxd = d[4];
        repeat (H) @(negedge clk_50M);
        reset = 1'b1;
        @(negedge clk_50M);
        reset = 1'b0;
        uart_rxd = 1'b1;
        chk_zero("t6_rst");
        idle(2 * C);
        chk("t6_no_strobe", n_strb, s0);
        send(8'hA5, 1'b0, 1'b1);
        idle(C);
        chk("t6_strobes", n_strb, s0 + 1);

        // random frames: mixed parity faults, framing faults, gaps
        for (int k = 0; k < 40; k++) begin
            d  = 8'($urandom_range(0, 255));
            pb = (^d) ^ ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 4) != 0);
            send(d, pb, st);
            if (!st) begin
                repeat ($urandom_range(1, 2 * C)) @(negedge clk_50M);
                idle($urandom_range(4, C));
            end else begin
                idle($urandom_range(0, C));
            end
        end

        w = 0;
        while (exp_q.size() != 0 && w < 20 * C) begin
            @(negedge clk_50M);
            w++;
        end
        chk("drain", exp_q.size(), 0);
        chk("strobe_total", n_strb, n_sent);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
